// File: rtl/wish_pack_pkg.sv
// Shared helpers for the Wishbone width packer: lane index width,
// endianness lane mapping and reset values.
package wish_pack_pkg;

    // Value of a register bit while the active-low reset is held
    localparam logic RST_BIT = 1'b0;

    // Level of rst_i that means "in reset"
    localparam logic RST_ACTIVE = 1'b0;

    // Width of the beat index counter, at least one bit
    function automatic int lane_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Lane that beat number idx is written to
    function automatic int lane_sel(
        input int idx,
        input int n,
        input bit le
    );
        return le ? idx : (n - 1 - idx);
    endfunction

endpackage

// File: rtl/wish_pack_acc.sv
// Lane accumulator and beat index for wish_pack.
// Ports: beat_i writes dat_i/tgc_i into the current lane; clr_i empties
// the word; word_o/tag_o give the word including the current beat.
module wish_pack_acc
    import wish_pack_pkg::*;
#(
    parameter int DW = 8,
    parameter int NP = 4,
    parameter bit LE = 1'b1,
    parameter int TW = 2,
    parameter int LW = lane_w(NP)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             beat_i,
    input  logic             clr_i,
    input  logic [DW-1:0]    dat_i,
    input  logic [TW-1:0]    tgc_i,
    output logic [LW-1:0]    idx_o,
    output logic             fin_o,
    output logic [DW*NP-1:0] word_o,
    output logic [TW-1:0]    tag_o
);

    logic [LW-1:0]    idx_q, idx_d;
    logic [DW*NP-1:0] acc_q, acc_d;
    logic [TW-1:0]    tag_q, tag_d;

    assign idx_o = idx_q;
    assign fin_o = (idx_q == LW'(NP - 1));

    always_comb begin
        idx_d  = idx_q;
        acc_d  = acc_q;
        tag_d  = tag_q;
        word_o = acc_q;
        tag_o  = tag_q;
        if (beat_i) begin
            acc_d[lane_sel(int'(idx_q), NP, LE)*DW +: DW] = dat_i;
            idx_d  = idx_q + LW'(1);
            tag_d  = tag_q | tgc_i;
            word_o = acc_d;
            tag_o  = tag_d;
        end
        // Clearing on every transfer keeps lanes of a short
        // (flushed) word zero and stops data leaking between words.
        if (clr_i) begin
            idx_d = '0;
            acc_d = '0;
            tag_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (rst_i == RST_ACTIVE) begin
            idx_q <= '0;
            acc_q <= '0;
            tag_q <= '0;
        end else begin
            idx_q <= idx_d;
            acc_q <= acc_d;
            tag_q <= tag_d;
        end
    end

endmodule

// File: rtl/wish_pack.sv
// Wishbone width packer: NUM_PACK narrow source beats -> one wide word.
// Ports: s_* narrow source (zero-latency ack, stall on busy output),
// d_* wide destination held until d_ack_i. Optional macro
// WISH_PACK_CYC_FLUSH_EN flushes partial words when s_cyc_i drops.
module wish_pack
    import wish_pack_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int NUM_PACK      = 4,
    parameter int TGC_WIDTH     = 2,
    parameter bit LITTLE_ENDIAN = 1'b1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           s_stb_i,
    input  logic                           s_cyc_i,
    output logic                           s_ack_o,
    output logic                           s_stall_o,
    input  logic [DATA_WIDTH-1:0]          s_dat_i,
    input  logic [TGC_WIDTH-1:0]           s_tgc_i,
    output logic                           d_stb_o,
    output logic                           d_cyc_o,
    input  logic                           d_ack_i,
    output logic [DATA_WIDTH*NUM_PACK-1:0] d_dat_o,
    output logic [TGC_WIDTH-1:0]           d_tgc_o
);

    localparam int LW = lane_w(NUM_PACK);
    localparam int WW = DATA_WIDTH * NUM_PACK;

    logic           d_stb_q, d_stb_d;
    logic [WW-1:0]  d_dat_q, d_dat_d;
    logic [TGC_WIDTH-1:0] d_tgc_q, d_tgc_d;

    logic           out_free;
    logic           flush_req;
    logic           xfer;
    logic           fin;
    logic [LW-1:0]  idx;
    logic [WW-1:0]  word;
    logic [TGC_WIDTH-1:0] tag;

    wish_pack_acc #(
        .DW (DATA_WIDTH),
        .NP (NUM_PACK),
        .LE (LITTLE_ENDIAN),
        .TW (TGC_WIDTH),
        .LW (LW)
    ) u_acc (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .beat_i (s_ack_o),
        .clr_i  (xfer),
        .dat_i  (s_dat_i),
        .tgc_i  (s_tgc_i),
        .idx_o  (idx),
        .fin_o  (fin),
        .word_o (word),
        .tag_o  (tag)
    );

    // Output register can take a new word this cycle
    assign out_free = ~d_stb_q | d_ack_i;

`ifdef WISH_PACK_CYC_FLUSH_EN
    logic flush_pend_q, flush_pend_d;

    // A dropped cycle with a partial word requests a flush; the
    // request is remembered until the output register is free.
    always_comb begin
        flush_req    = flush_pend_q | (~s_cyc_i & (idx != '0));
        flush_pend_d = flush_req & ~out_free;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (rst_i == RST_ACTIVE) begin
            flush_pend_q <= RST_BIT;
        end else begin
            flush_pend_q <= flush_pend_d;
        end
    end
`else
    assign flush_req = 1'b0;
`endif

    // Only the final beat can stall, so partial words stream at
    // full rate; both handshake outputs stay low in reset.
    always_comb begin
        s_stall_o = 1'b0;
        s_ack_o   = 1'b0;
        if (rst_i != RST_ACTIVE) begin
            s_stall_o = flush_req
                      | (s_stb_i & s_cyc_i & fin & ~out_free);
            s_ack_o   = s_stb_i & s_cyc_i & ~s_stall_o;
        end
    end

    assign xfer = (s_ack_o & fin) | (flush_req & out_free);

    always_comb begin
        d_stb_d = d_stb_q;
        d_dat_d = d_dat_q;
        d_tgc_d = d_tgc_q;
        if (d_stb_q & d_ack_i) begin
            d_stb_d = 1'b0;
        end
        if (xfer) begin
            d_stb_d = 1'b1;
            d_dat_d = word;
            d_tgc_d = tag;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (rst_i == RST_ACTIVE) begin
            d_stb_q <= RST_BIT;
            d_dat_q <= '0;
            d_tgc_q <= '0;
        end else begin
            d_stb_q <= d_stb_d;
            d_dat_q <= d_dat_d;
            d_tgc_q <= d_tgc_d;
        end
    end

    assign d_stb_o = d_stb_q;
    assign d_cyc_o = d_stb_q;
    assign d_dat_o = d_dat_q;
    assign d_tgc_o = d_tgc_q;

endmodule

// File: tb/tb_wish_pack.sv
// Scoreboard bench for wish_pack, little- and big-endian instances
// driven in parallel; expected words are queued as stimulus is sent.
module tb_wish_pack;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        s_stb_i = 1'b0;
    logic        s_cyc_i = 1'b0;
    logic [7:0]  s_dat_i = '0;
    logic [1:0]  s_tgc_i = '0;
    logic        d_ack_i = 1'b1;

    logic        s_ack_o, s_stall_o, d_stb_o, d_cyc_o;
    logic [31:0] d_dat_o;
    logic [1:0]  d_tgc_o;

    logic        b_ack, b_stall, b_stb, b_cyc;
    logic [31:0] b_dat;
    logic [1:0]  b_tgc;

    int n_checks = 0;
    int n_fail = 0;
    int stall_cnt = 0;
    int word_cnt = 0;

    logic [33:0] sb[$];
    logic [33:0] e;
    logic        hold_v = 1'b0;
    logic [31:0] hold_dat;
    logic [1:0]  hold_tgc;

    always #5 clk_i = ~clk_i;

    wish_pack #(
        .DATA_WIDTH(8), .NUM_PACK(4),
        .TGC_WIDTH(2), .LITTLE_ENDIAN(1'b1)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .s_stb_i(s_stb_i), .s_cyc_i(s_cyc_i),
        .s_ack_o(s_ack_o), .s_stall_o(s_stall_o),
        .s_dat_i(s_dat_i), .s_tgc_i(s_tgc_i),
        .d_stb_o(d_stb_o), .d_cyc_o(d_cyc_o),
        .d_ack_i(d_ack_i), .d_dat_o(d_dat_o),
        .d_tgc_o(d_tgc_o)
    );

    wish_pack #(
        .DATA_WIDTH(8), .NUM_PACK(4),
        .TGC_WIDTH(2), .LITTLE_ENDIAN(1'b0)
    ) dut_be (
        .clk_i(clk_i), .rst_i(rst_i),
        .s_stb_i(s_stb_i), .s_cyc_i(s_cyc_i),
        .s_ack_o(b_ack), .s_stall_o(b_stall),
        .s_dat_i(s_dat_i), .s_tgc_i(s_tgc_i),
        .d_stb_o(b_stb), .d_cyc_o(b_cyc),
        .d_ack_i(d_ack_i), .d_dat_o(b_dat),
        .d_tgc_o(b_tgc)
    );

    function automatic logic [31:0] swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // Monitor: handshake rules, hold stability, scoreboard pops
    always @(negedge clk_i) begin
        #2;
        if (!rst_i) begin
            hold_v = 1'b0;
        end else begin
            n_checks++;
            if (s_ack_o && s_stall_o) begin
                n_fail++;
                $display("FAIL ack_stall: ack=%b stall=%b want not both",
                         s_ack_o, s_stall_o);
            end
            if (s_stall_o) stall_cnt++;
            n_checks++;
            if (d_cyc_o !== d_stb_o || b_cyc !== b_stb) begin
                n_fail++;
                $display("FAIL cyc_eq_stb: cyc=%b stb=%b want equal",
                         d_cyc_o, d_stb_o);
            end
            if (hold_v) begin
                n_checks++;
                if (!d_stb_o || d_dat_o !== hold_dat
                    || d_tgc_o !== hold_tgc) begin
                    n_fail++;
                    $display("FAIL hold: stb=%b dat=%h tgc=%b want 1 %h %b",
                             d_stb_o, d_dat_o, d_tgc_o,
                             hold_dat, hold_tgc);
                end
            end
            hold_v   = d_stb_o && !d_ack_i;
            hold_dat = d_dat_o;
            hold_tgc = d_tgc_o;
            if (d_stb_o && d_ack_i) begin
                word_cnt++;
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_empty: got word %h want none",
                             d_dat_o);
                end else begin
                    e = sb.pop_front();
                    if (d_dat_o !== e[31:0] || d_tgc_o !== e[33:32]) begin
                        n_fail++;
                        $display("FAIL le_word: got %h/%b want %h/%b",
                                 d_dat_o, d_tgc_o, e[31:0], e[33:32]);
                    end
                    n_checks++;
                    if (!b_stb || b_dat !== swap(e[31:0])
                        || b_tgc !== e[33:32]) begin
                        n_fail++;
                        $display("FAIL be_word: got %b %h/%b want %h/%b",
                                 b_stb, b_dat, b_tgc,
                                 swap(e[31:0]), e[33:32]);
                    end
                end
            end
        end
    end

    task automatic send_beat(input logic [7:0] d, input logic [1:0] t);
        int n;
        n = 0;
        @(negedge clk_i);
        s_stb_i = 1'b1;
        s_cyc_i = 1'b1;
        s_dat_i = d;
        s_tgc_i = t;
        forever begin
            #1;
            if (s_ack_o) break;
            @(negedge clk_i);
            n++;
            if (n > 50) begin
                n_checks++;
                n_fail++;
                $display("FAIL beat_timeout: beat %h ack=0 want 1", d);
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk_i);
        s_stb_i = 1'b0;
        s_cyc_i = 1'b0;
        repeat (n) @(negedge clk_i);
    endtask

    task automatic test_reset();
        rst_i   = 1'b0;
        s_stb_i = 1'b1;
        s_cyc_i = 1'b1;
        repeat (2) @(negedge clk_i);
        #1;
        n_checks++;
        if (s_ack_o !== 1'b0 || s_stall_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_hs: ack=%b stall=%b want 0 0",
                     s_ack_o, s_stall_o);
        end
        n_checks++;
        if (d_stb_o !== 1'b0 || d_cyc_o !== 1'b0
            || d_dat_o !== 32'h0 || d_tgc_o !== 2'b00) begin
            n_fail++;
            $display("FAIL rst_out: stb=%b cyc=%b dat=%h tgc=%b want 0",
                     d_stb_o, d_cyc_o, d_dat_o, d_tgc_o);
        end
        @(negedge clk_i);
        s_stb_i = 1'b0;
        s_cyc_i = 1'b0;
        rst_i   = 1'b1;
        idle(1);
    endtask

    task automatic test_le_pack();
        int w0;
        w0 = word_cnt;
        sb.push_back({2'b00, 32'h44332211});
        send_beat(8'h11, 2'b00);
        send_beat(8'h22, 2'b00);
        send_beat(8'h33, 2'b00);
        send_beat(8'h44, 2'b00);
        idle(4);
        n_checks++;
        if (word_cnt - w0 !== 1) begin
            n_fail++;
            $display("FAIL one_pulse: got %0d words want 1",
                     word_cnt - w0);
        end
    endtask

    task automatic test_tags();
        sb.push_back({2'b11, 32'h08070605});
        send_beat(8'h05, 2'b01);
        send_beat(8'h06, 2'b00);
        send_beat(8'h07, 2'b10);
        send_beat(8'h08, 2'b00);
        sb.push_back({2'b00, 32'h0c0b0a09});
        send_beat(8'h09, 2'b00);
        send_beat(8'h0a, 2'b00);
        send_beat(8'h0b, 2'b00);
        send_beat(8'h0c, 2'b00);
        idle(4);
    endtask

    task automatic test_back_to_back();
        int w0;
        w0 = word_cnt;
        stall_cnt = 0;
        d_ack_i = 1'b0;
        sb.push_back({2'b01, 32'h04030201});
        sb.push_back({2'b10, 32'h08070605});
        fork
            begin
                for (int i = 1; i <= 8; i++) begin
                    send_beat(8'(i), (i == 2) ? 2'b01 :
                              (i == 7) ? 2'b10 : 2'b00);
                end
            end
            begin
                repeat (10) @(negedge clk_i);
                d_ack_i = 1'b1;
            end
        join
        idle(4);
        n_checks++;
        if (stall_cnt !== 2) begin
            n_fail++;
            $display("FAIL b2b_stall: got %0d stall cycles want 2",
                     stall_cnt);
        end
        n_checks++;
        if (word_cnt - w0 !== 2) begin
            n_fail++;
            $display("FAIL b2b_words: got %0d words want 2",
                     word_cnt - w0);
        end
    endtask

    task automatic test_reset_mid();
        send_beat(8'hAA, 2'b11);
        send_beat(8'hBB, 2'b11);
        @(negedge clk_i);
        rst_i   = 1'b0;
        s_stb_i = 1'b1;
        s_cyc_i = 1'b1;
        s_dat_i = 8'hCC;
        #1;
        n_checks++;
        if (s_ack_o !== 1'b0 || b_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_rst_ack: ack=%b want 0", s_ack_o);
        end
        @(negedge clk_i);
        rst_i   = 1'b1;
        s_stb_i = 1'b0;
        sb.push_back({2'b00, 32'h04030201});
        send_beat(8'h01, 2'b00);
        send_beat(8'h02, 2'b00);
        send_beat(8'h03, 2'b00);
        send_beat(8'h04, 2'b00);
        idle(4);
    endtask

    task automatic test_cyc_gap();
`ifdef WISH_PACK_CYC_FLUSH_EN
        sb.push_back({2'b00, 32'h00002211});
        send_beat(8'h11, 2'b00);
        send_beat(8'h22, 2'b00);
        idle(4);
        sb.push_back({2'b00, 32'h00004433});
        send_beat(8'h33, 2'b00);
        send_beat(8'h44, 2'b00);
        idle(4);
`else
        sb.push_back({2'b00, 32'h44332211});
        send_beat(8'h11, 2'b00);
        send_beat(8'h22, 2'b00);
        idle(4);
        send_beat(8'h33, 2'b00);
        send_beat(8'h44, 2'b00);
        idle(4);
`endif
    endtask

    initial begin
        test_reset();
        test_le_pack();
        test_tags();
        test_back_to_back();
        test_reset_mid();
        test_cyc_gap();
        idle(5);
        n_checks++;
        if (sb.size() !== 0) begin
            n_fail++;
            $display("FAIL sb_left: %0d words pending want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
